mua_frame_arbiter: RTL and testbench
====================================

# mua_frame_arbiter

Frame-aware round-robin arbiter that shares the single MUA reorder datapath between several MUA sources (e.g. multiple headstage ports). Each source delivers fixed-length MUA frames tagged with a start-of-frame marker. The arbiter grants one source at a time for exactly one whole frame, so frames from different sources never interleave. It drives the reorder block's valid/data input with ready-based backpressure, resynchronises sources that lose frame alignment, and reports frame, drop and error statistics.

## Interface

- N_SRC, 2, number of requesting sources (2..8)
- FRAME_LEN, 160, words per MUA frame (≥2)
- DW, 32, data word width
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- src_valid  in  N_SRC  per-source word valid
- src_sof  in  N_SRC  per-source start-of-frame, qualified by src_valid
- src_data  in  N_SRC*DW  per-source data; source i occupies bits [i*DW +: DW]
- src_ready  out  N_SRC  per-source accept
- muar_valid  out  1  word valid to reorder input
- muar_data  out  DW  word to reorder input
- muar_ready  in  1  reorder input can accept (driven as !fifo_full)
- grant_id  out  clog2(N_SRC)  index of current or last granted source
- busy  out  1  high in XFER
- frame_done  out  1  one-cycle pulse on last word handshake of a frame
- err_sof  out  1  one-cycle pulse: sof seen on granted source at word index >0
- frame_cnt  out  32  completed frames, wraps
- drop_cnt  out  16  words discarded in IDLE, saturates at 0xFFFF

## Operation

- A handshake on source i or on the output occurs when valid and ready are both high in the same clk cycle.
- FSM states: IDLE and XFER.
- IDLE:
  - Round-robin scan starts at index last_grant+1 (mod N_SRC). After reset, scan starts at 0.
  - First source with src_valid && src_sof wins. Register grant_id and enter XFER with word_idx=0.
  - The sof word is not consumed in IDLE.
  - Any source presenting src_valid && !src_sof gets src_ready=1; that word is discarded and drop_cnt increments by one per discarded word (multiple sources in one cycle add their count).
  - muar_valid=0.
- XFER, granted source g:
  - muar_valid = src_valid[g]; muar_data = src_data[g]; src_ready[g] = muar_ready. All combinational, zero latency.
  - All other src_ready = 0; their words are held, not dropped.
  - word_idx increments on each output handshake.
  - On the handshake with word_idx == FRAME_LEN-1: pulse frame_done, increment frame_cnt, set last_grant=g, return to IDLE.
- Mid-frame sof: a handshake word with src_sof=1 at word_idx>0 pulses err_sof. The word is still forwarded and counted; the frame ends by count only.
- word_idx is clog2(FRAME_LEN) bits wide and is cleared on entering XFER.
- Reset mid-frame: state returns to IDLE and the partial frame is abandoned. The reorder side sees a truncated frame; this is acceptable and handled by a system-level flush.

## Timing

- Reset values:
  - state=IDLE, last_grant=N_SRC-1, grant_id=0
  - src_ready=0, muar_valid=0, muar_data=0 (data muxed from source 0 is don't-care but must not be X-propagated as valid)
  - busy=0, frame_done=0, err_sof=0, frame_cnt=0, drop_cnt=0
- Arbitration latency:
  - sof presented in cycle t (state IDLE) → busy=1 and first word forwardable in cycle t+1.
  - Frame end handshake in cycle t → IDLE in t+1 → next grant in XFER at t+2.
  - This gives one bubble cycle per frame.
- Throughput with muar_ready=1 and continuous source valid: FRAME_LEN words per FRAME_LEN+1 cycles.
- frame_done and err_sof are registered, asserted in the cycle after the causing handshake. frame_cnt and drop_cnt update in the same cycle as the pulse.
- Output valid never depends on muar_ready; there is no combinational path from muar_ready to muar_valid.
- Simultaneous sof on multiple sources: only the round-robin winner is granted; the others wait with src_ready=0.

## Test plan

Sim uses FRAME_LEN=4, N_SRC=2.

- Source 0 sends sof+3 words (0xA0..0xA3), muar_ready=1 → muar_data sequence A0,A1,A2,A3 on 4 consecutive cycles; frame_done single pulse; frame_cnt=1; grant_id=0.
- Both sources raise sof in the same cycle after reset, frames A0..A3 and B0..B3 → A0..A3 forwarded, then B0..B3 after one idle cycle. Next simultaneous sof → source 0 granted again (last_grant=1). frame_cnt=3 after the third frame.
- muar_ready toggles 1,0,1,0… during the source-0 frame → exactly 4 output handshakes, no duplicate or lost word, frame_done after the 4th handshake, src_ready[0] mirrors muar_ready.
- Source 1 sends 3 non-sof words while IDLE, then a proper frame → drop_cnt=3; the frame forwards intact; err_sof stays 0.
- Source 0 sends sof, w1, sof, w3 → err_sof pulses once, after the 3rd handshake; all 4 words forwarded; frame_done after w3; next frame arbitrates normally.
- rst asserted for 1 cycle after the 2nd word of a frame → the next cycle shows busy=0, muar_valid=0 and all counters 0. A fresh sof frame then completes with frame_cnt=1.

Source files
------------

// File: rtl/mua_frame_arbiter.sv
// mua_frame_arbiter: frame-granular round-robin arbiter feeding the shared MUA reorder input.
// One source owns the output for a whole FRAME_LEN-word frame; stray non-sof words are dropped while idle.
module mua_frame_arbiter #(
   parameter int N_SRC = 2,
   parameter int FRAME_LEN = 160,
   parameter int DW = 32,
   localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
   localparam int WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  src_valid,
   input  logic [N_SRC-1:0]  src_sof,
   input  logic [N_SRC*DW-1:0] src_data,
   output logic [N_SRC-1:0]  src_ready,
   output logic              muar_valid,
   output logic [DW-1:0]     muar_data,
   input  logic              muar_ready,
   output logic [GW-1:0]     grant_id,
   output logic              busy,
   output logic              frame_done,
   output logic              err_sof,
   output logic [31:0]       frame_cnt,
   output logic [15:0]       drop_cnt
);
   typedef enum logic {IDLE, XFER} state_t;
   state_t state_q, state_d;
   logic [GW-1:0] grant_q, grant_d, last_q, last_d, win;
   logic [WW-1:0] idx_q, idx_d;
   logic frame_done_q, frame_done_d, err_sof_q, err_sof_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;
   logic [3:0] n_drop;
   logic [N_SRC-1:0] drop_vec;
   logic found, hs, last_word;

   // Index of the k-th candidate after base, wrapping at N_SRC (base+1+k never exceeds 2*N_SRC-1).
   function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
      int v;
      v = int'(base) + 1 + k;
      return GW'(v >= N_SRC ? v - N_SRC : v);
   endfunction

   always_comb begin
      found = 1'b0;
      win = '0;
      for (int k = 0; k < N_SRC; k++)
         if (!found && src_valid[rr_idx(last_q, k)] && src_sof[rr_idx(last_q, k)]) begin
            found = 1'b1;
            win = rr_idx(last_q, k);
         end
   end

   assign drop_vec = (state_q == IDLE) ? (src_valid & ~src_sof) : '0;

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < N_SRC; i++) n_drop = n_drop + 4'(drop_vec[i]);
   end

   assign busy = state_q == XFER;
   assign hs = busy && src_valid[grant_q] && muar_ready;
   assign last_word = idx_q == WW'(FRAME_LEN - 1);
   assign muar_valid = busy && src_valid[grant_q];
   assign muar_data = busy ? src_data[int'(grant_q)*DW +: DW] : '0;
   assign src_ready = busy ? (N_SRC'(muar_ready) << grant_q) : drop_vec;
   assign grant_id = grant_q;
   assign frame_done = frame_done_q;
   assign err_sof = err_sof_q;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d = last_q;
      idx_d = idx_q;
      frame_done_d = 1'b0;
      err_sof_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      drop_sum = {1'b0, drop_cnt_q} + 17'(n_drop);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (state_q == IDLE) begin
         if (found) begin
            state_d = XFER;
            grant_d = win;
            idx_d = '0;
         end
      end else if (hs) begin
         idx_d = idx_q + 1'b1;
         err_sof_d = src_sof[grant_q] && (idx_q != '0);
         if (last_word) begin
            frame_done_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 32'd1;
            last_d = grant_q;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q <= GW'(N_SRC - 1);
         idx_q <= '0;
         frame_done_q <= 1'b0;
         err_sof_q <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q <= last_d;
         idx_q <= idx_d;
         frame_done_q <= frame_done_d;
         err_sof_q <= err_sof_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
endmodule

// File: tb/tb_mua_frame_arbiter.sv
// tb_mua_frame_arbiter: directed scenarios for the frame arbiter with FRAME_LEN=4, N_SRC=2.
module tb_mua_frame_arbiter;
   localparam int N = 2, FL = 4, DW = 32;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] src_valid = '0, src_sof = '0, src_ready;
   logic [N*DW-1:0] src_data = '0;
   logic muar_valid, muar_ready = 1'b1, busy, frame_done, err_sof;
   logic [DW-1:0] muar_data;
   logic [0:0] grant_id;
   logic [31:0] frame_cnt;
   logic [15:0] drop_cnt;
   int errors = 0, checks = 0, cyc = 0, mirror_bad = 0;
   logic rdy_tog = 1'b0;
   logic [32:0] q0[$], q1[$];
   logic [31:0] out_log[$];
   int hs_cyc[$], done_cyc[$], err_cyc[$];

   mua_frame_arbiter #(.N_SRC(N), .FRAME_LEN(FL), .DW(DW)) dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_sof(src_sof), .src_data(src_data),
      .src_ready(src_ready), .muar_valid(muar_valid), .muar_data(muar_data), .muar_ready(muar_ready),
      .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .err_sof(err_sof),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ow(input int i);
      return i < out_log.size() ? out_log[i] : 32'hDEAD_DEAD;
   endfunction
   function automatic int hc(input int i);
      return i < hs_cyc.size() ? hs_cyc[i] : -100;
   endfunction
   function automatic int dc(input int i);
      return i < done_cyc.size() ? done_cyc[i] : -100;
   endfunction

   task automatic push(input int s, input logic sof, input logic [31:0] d);
      if (s == 0) q0.push_back({sof, d});
      else q1.push_back({sof, d});
   endtask

   task automatic push_frame(input int s, input logic [31:0] base);
      for (int i = 0; i < FL; i++) push(s, i == 0, base + 32'(i));
   endtask

   // One clock: present queue heads, sample mid-cycle, pop words the DUT accepted.
   task automatic tick();
      @(posedge clk); #1;
      if (rdy_tog) muar_ready = ~muar_ready;
      src_valid[0] = q0.size() != 0;
      src_sof[0] = q0.size() != 0 ? q0[0][32] : 1'b0;
      src_data[31:0] = q0.size() != 0 ? q0[0][31:0] : 32'h0;
      src_valid[1] = q1.size() != 0;
      src_sof[1] = q1.size() != 0 ? q1[0][32] : 1'b0;
      src_data[63:32] = q1.size() != 0 ? q1[0][31:0] : 32'h0;
      #4;
      if (muar_valid && muar_ready) begin
         out_log.push_back(muar_data);
         hs_cyc.push_back(cyc);
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (err_sof) err_cyc.push_back(cyc);
      if (busy && src_ready !== (N'(muar_ready) << grant_id)) mirror_bad++;
      if (src_valid[0] && src_ready[0]) void'(q0.pop_front());
      if (src_valid[1] && src_ready[1]) void'(q1.pop_front());
      cyc++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      src_valid = '0; src_sof = '0; src_data = '0;
      rdy_tog = 1'b0; muar_ready = 1'b1;
      q0.delete(); q1.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_log.delete(); hs_cyc.delete(); done_cyc.delete(); err_cyc.delete();
      mirror_bad = 0; cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #5;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (muar_valid !== 1'b0) begin errors++; $display("FAIL rst_muar_valid got=%b exp=0", muar_valid); end
      checks++; if (muar_data !== 32'h0) begin errors++; $display("FAIL rst_muar_data got=%h exp=0", muar_data); end
      checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL rst_src_ready got=%b exp=00", src_ready); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant got=%b exp=0", grant_id); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
      checks++; if (err_sof !== 1'b0) begin errors++; $display("FAIL rst_err_sof got=%b exp=0", err_sof); end
      checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
   endtask

   task automatic test_single_frame();
      do_reset();
      push_frame(0, 32'hA0);
      repeat (8) tick();
      checks++; if (out_log.size() != 4) begin errors++; $display("FAIL t1_count got=%0d exp=4", out_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ow(i) !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL t1_word%0d got=%h exp=%h", i, ow(i), 32'hA0 + 32'(i)); end
      end
      checks++; if (hc(0) != 1) begin errors++; $display("FAIL t1_first_cycle got=%0d exp=1", hc(0)); end
      checks++; if (hc(3) != 4) begin errors++; $display("FAIL t1_last_cycle got=%0d exp=4", hc(3)); end
      checks++; if (done_cyc.size() != 1 || dc(0) != 5) begin errors++; $display("FAIL t1_done got=%0d@%0d exp=1@5", done_cyc.size(), dc(0)); end
      checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL t1_frame_cnt got=%0d exp=1", frame_cnt); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL t1_grant got=%b exp=0", grant_id); end
   endtask

   task automatic test_round_robin();
      do_reset();
      push_frame(0, 32'hA0);
      push_frame(1, 32'hB0);
      repeat (12) tick();
      checks++; if (out_log.size() != 8) begin errors++; $display("FAIL t2_count got=%0d exp=8", out_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ow(i) !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL t2_a%0d got=%h exp=%h", i, ow(i), 32'hA0 + 32'(i)); end
         checks++; if (ow(i + 4) !== 32'hB0 + 32'(i)) begin errors++; $display("FAIL t2_b%0d got=%h exp=%h", i, ow(i + 4), 32'hB0 + 32'(i)); end
      end
      checks++; if (hc(4) - hc(3) != 2) begin errors++; $display("FAIL t2_bubble got=%0d exp=2", hc(4) - hc(3)); end
      push_frame(0, 32'hC0);
      push_frame(1, 32'hD0);
      repeat (6) tick();
      checks++; if (ow(8) !== 32'hC0) begin errors++; $display("FAIL t2_rr_winner got=%h exp=c0", ow(8)); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL t2_grant3 got=%b exp=0", grant_id); end
      checks++; if (frame_cnt !== 32'd3) begin errors++; $display("FAIL t2_frame_cnt3 got=%0d exp=3", frame_cnt); end
      repeat (6) tick();
      checks++; if (ow(12) !== 32'hD0 || ow(15) !== 32'hD3) begin errors++; $display("FAIL t2_d_frame got=%h..%h exp=d0..d3", ow(12), ow(15)); end
      checks++; if (frame_cnt !== 32'd4) begin errors++; $display("FAIL t2_frame_cnt4 got=%0d exp=4", frame_cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
      push_frame(0, 32'hA0);
      rdy_tog = 1'b1;
      repeat (12) tick();
      checks++; if (out_log.size() != 4) begin errors++; $display("FAIL t3_count got=%0d exp=4", out_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ow(i) !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL t3_word%0d got=%h exp=%h", i, ow(i), 32'hA0 + 32'(i)); end
      end
      checks++; if (hc(0) != 1 || hc(3) != 7) begin errors++; $display("FAIL t3_spacing got=%0d,%0d exp=1,7", hc(0), hc(3)); end
      checks++; if (done_cyc.size() != 1 || dc(0) != 8) begin errors++; $display("FAIL t3_done got=%0d@%0d exp=1@8", done_cyc.size(), dc(0)); end
      checks++; if (mirror_bad != 0) begin errors++; $display("FAIL t3_ready_mirror got=%0d exp=0", mirror_bad); end
   endtask

   task automatic test_drop();
      do_reset();
      push(1, 1'b0, 32'h11); push(1, 1'b0, 32'h12); push(1, 1'b0, 32'h13);
      push_frame(1, 32'hB0);
      repeat (10) tick();
      checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL t4_drop_cnt got=%0d exp=3", drop_cnt); end
      checks++; if (out_log.size() != 4) begin errors++; $display("FAIL t4_count got=%0d exp=4", out_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ow(i) !== 32'hB0 + 32'(i)) begin errors++; $display("FAIL t4_word%0d got=%h exp=%h", i, ow(i), 32'hB0 + 32'(i)); end
      end
      checks++; if (err_cyc.size() != 0) begin errors++; $display("FAIL t4_err_sof got=%0d exp=0", err_cyc.size()); end
      checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL t4_grant got=%b exp=1", grant_id); end
      push(0, 1'b0, 32'h21); push(0, 1'b0, 32'h22);
      push(1, 1'b0, 32'h31); push(1, 1'b0, 32'h32);
      repeat (3) tick();
      checks++; if (drop_cnt !== 16'd7) begin errors++; $display("FAIL t4_multi_drop got=%0d exp=7", drop_cnt); end
   endtask

   task automatic test_mid_sof();
      do_reset();
      push(0, 1'b1, 32'hE0); push(0, 1'b0, 32'hE1); push(0, 1'b1, 32'hE2); push(0, 1'b0, 32'hE3);
      push_frame(0, 32'hF0);
      repeat (12) tick();
      checks++; if (err_cyc.size() != 1) begin errors++; $display("FAIL t5_err_count got=%0d exp=1", err_cyc.size()); end
      checks++; if ((err_cyc.size() != 0 ? err_cyc[0] : -1) != 4) begin errors++; $display("FAIL t5_err_cycle got=%0d exp=4", err_cyc.size() != 0 ? err_cyc[0] : -1); end
      checks++; if (out_log.size() != 8) begin errors++; $display("FAIL t5_count got=%0d exp=8", out_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ow(i) !== 32'hE0 + 32'(i)) begin errors++; $display("FAIL t5_e%0d got=%h exp=%h", i, ow(i), 32'hE0 + 32'(i)); end
         checks++; if (ow(i + 4) !== 32'hF0 + 32'(i)) begin errors++; $display("FAIL t5_f%0d got=%h exp=%h", i, ow(i + 4), 32'hF0 + 32'(i)); end
      end
      checks++; if (done_cyc.size() != 2 || dc(0) != 5 || dc(1) != 10) begin errors++; $display("FAIL t5_done got=%0d@%0d,%0d exp=2@5,10", done_cyc.size(), dc(0), dc(1)); end
      checks++; if (hc(4) != 6) begin errors++; $display("FAIL t5_next_start got=%0d exp=6", hc(4)); end
      checks++; if (frame_cnt !== 32'd2) begin errors++; $display("FAIL t5_frame_cnt got=%0d exp=2", frame_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      push(1, 1'b0, 32'h99);
      push_frame(0, 32'h40);
      push_frame(0, 32'h50);
      repeat (8) tick();
      checks++; if (frame_cnt !== 32'd1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL t6_pre got=%0d/%0d exp=1/1", frame_cnt, drop_cnt); end
      checks++; if (ow(5) !== 32'h51 || busy !== 1'b1) begin errors++; $display("FAIL t6_partial got=%h busy=%b exp=51 busy=1", ow(5), busy); end
      @(posedge clk); #1;
      rst = 1'b1;
      q0.delete(); q1.delete();
      src_valid = '0; src_sof = '0; src_data = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      #4;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got=%b exp=0", busy); end
      checks++; if (muar_valid !== 1'b0) begin errors++; $display("FAIL t6_muar_valid got=%b exp=0", muar_valid); end
      checks++; if (frame_cnt !== 32'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL t6_counters got=%0d/%0d exp=0/0", frame_cnt, drop_cnt); end
      checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL t6_src_ready got=%b exp=00", src_ready); end
      out_log.delete();
      push_frame(0, 32'h60);
      repeat (7) tick();
      checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL t6_fresh_cnt got=%0d exp=1", frame_cnt); end
      checks++; if (out_log.size() != 4 || ow(0) !== 32'h60 || ow(3) !== 32'h63) begin errors++; $display("FAIL t6_fresh_data got=%0d:%h..%h exp=4:60..63", out_log.size(), ow(0), ow(3)); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_backpressure();
      test_drop();
      test_mid_sof();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
